width_gearbox: RTL and testbench
================================

// Module: width_gearbox
// PURPOSE
//  Parametrised LSB-first bit-stream width converter (gearbox) with valid/ready on both sides.
//  Packs IN_W-bit input words into a bit buffer and emits OUT_W-bit output words. Any IN_W/OUT_W ratio is supported.
//  Supports backpressure and an end-of-stream flush that zero-pads the final partial word.
//  Sits between a fixed-width ingress (e.g. 16-bit bus) and symbol-width consumers (e.g. 10-bit).
// PARAMETERS
//  IN_W   16  input word width, >=1
//  OUT_W  10  output word width, >=1
//  BUF_W  IN_W+OUT_W  bit-buffer capacity; derived, do not override
//  CNT_W  $clog2(BUF_W+1)  fill-counter width; derived
// PORTS
//  clk         in   1      clock, all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  in_data     in   IN_W   input word; bit 0 is the oldest bit in the stream
//  in_valid    in   1      input word present
//  in_ready    out  1      block accepts in_data this cycle
//  flush       in   1      single-cycle request: drain and pad the remaining bits
//  out_data    out  OUT_W  output word; bit 0 is the oldest bit
//  out_valid   out  1      out_data valid
//  out_ready   in   1      consumer accepts out_data
//  out_last    out  1      current out_data is the final (padded) word of a flush
//  flush_done  out  1      1-cycle pulse when the flush completes
//  fill_level  out  CNT_W  bits currently held in the buffer
// BEHAVIOUR
//  - Reset: buffer=0, count=0, state=RUN; out_valid=0, out_last=0, flush_done=0, fill_level=0, out_data=0. in_ready=1.
//  - rst mid-operation discards all buffered bits and any pending flush, with no output. Accept at the first cycle after rst deasserts.
//  - All outputs are derived from registers only. There is no combinational path from in_valid/out_ready to in_ready/out_valid.
//  - Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - RUN state:
//      in_ready  = (count <= BUF_W-IN_W).
//      out_valid = (count >= OUT_W).
//      out_data  = buf[OUT_W-1:0].
//  - On pop, the buffer shifts right by OUT_W and count -= OUT_W.
//  - On accept, in_data is written at bit position (count, or count-OUT_W when popping the same cycle) and count += IN_W.
//  - Simultaneous accept and pop are legal: count_next = count + IN_W - OUT_W.
//  - Latency: a word accepted in cycle N that completes an output word gives out_valid in cycle N+1.
//  - Deadlock-free: count < OUT_W implies count <= BUF_W-IN_W, so in_ready is high.
//  - Flush:
//      * A flush sampled in RUN moves to FLUSH. An input accepted in that same cycle is kept.
//      * FLUSH state: in_ready=0. Full words drain normally.
//      * When 0 < count < OUT_W: out_valid=1, out_data = remaining bits with upper bits zero, out_last=1.
//      * Popping that padded word gives count=0, flush_done=1 for one cycle, then back to RUN.
//      * If count=0 on entry to FLUSH, or after draining, there is no padded word. flush_done pulses next cycle, then RUN.
//      * flush is ignored while in FLUSH.
//  - out_valid holds, and out_data stays stable, until pop (AXI-style). out_last is 0 except for the padded word.
//  - fill_level = count, registered.
// TESTING
//  1. IN_W=16, OUT_W=10, out_ready=1:
//     - in 0xABCD then 0xD234 -> out 0x3CD, then 0x12A; fill_level=12.
//  2. Continuing from 1, pulse flush:
//     - out 0x123 (out_last=0), then 0x003 (out_last=1), then flush_done pulse; fill_level=0; in_ready=1.
//  3. Backpressure, out_ready=0, stream 16-bit words:
//     - in_ready drops once count=16 (>10).
//     - out_data holds 0x3CD.
//     - No bits are lost after out_ready=1; 5 words in give 8 words out, with the pattern checked against a bit-level model.
//  4. Flush with count=0, and flush while FLUSH is active:
//     - Flush at count=0 -> no out_valid, flush_done pulses once.
//     - A second flush during FLUSH -> ignored.
//  5. Assert rst while count=12 and out_valid=1:
//     - Next cycle out_valid=0, fill_level=0, in_ready=1.
//     - The first post-reset word is aligned at bit 0.
//  6. Parameter sweep (8->8, 8->10, 10->8, 3->16) with random valid/ready:
//     - Output stream equals the input bit stream; a trailing flush pads only the final word.

Source files
------------

// File: rtl/width_gearbox.sv
// LSB-first bit-stream width converter: packs IN_W-bit input words into a
// bit buffer and emits OUT_W-bit output words, with valid/ready on both sides
// and an end-of-stream flush that zero-pads the final partial word.
module width_gearbox #(
    parameter  int IN_W  = 16,
    parameter  int OUT_W = 10,
    localparam int BUF_W = IN_W + OUT_W,
    localparam int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             flush_done,
    output logic [CNT_W-1:0] fill_level
);

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_t;

    localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);
    // Room for one more input word; equals OUT_W, so count < OUT_W always
    // leaves the input side open and the block cannot deadlock.
    localparam logic [CNT_W-1:0] ACC_MAX = CNT_W'(BUF_W - IN_W);

    state_t           state_q, state_d;
    logic [BUF_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] count_q, count_d, count_pop;
    logic             done_q, done_d;
    logic             accept, pop;

    // Handshake outputs, decoded from registered state and fill count only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            S_RUN: begin
                in_ready  = (count_q <= ACC_MAX);
                out_valid = (count_q >= OUT_CNT);
            end
            S_FLUSH: begin
                out_valid = (count_q != '0);
                out_last  = (count_q != '0) && (count_q < OUT_CNT);
            end
            default: ;
        endcase
    end

    // Bits above count are kept zero at all times, so the padded final word
    // needs no masking: it is simply the low OUT_W bits of the buffer.
    assign out_data   = bits_q[OUT_W-1:0];
    assign flush_done = done_q;
    assign fill_level = count_q;

    // Next buffer contents, fill count and state from this cycle's transfers.
    always_comb begin
        state_d   = state_q;
        bits_d    = bits_q;
        count_pop = count_q;
        done_d    = 1'b0;
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;

        if (pop) begin
            bits_d    = bits_q >> OUT_W;
            count_pop = (count_q >= OUT_CNT) ? (count_q - OUT_CNT) : '0;
        end

        count_d = count_pop;
        if (accept) begin
            // New word lands directly above the bits that survive any pop.
            bits_d  = bits_d | (BUF_W'(in_data) << count_pop);
            count_d = count_pop + IN_CNT;
        end

        case (state_q)
            S_RUN: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Buffer empty (on entry or after the last pop): finish.
                if (count_d == '0) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // State, buffer, fill count and completion pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            bits_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_width_gearbox.sv
// Self-checking bench for width_gearbox: five instances (16->10 plus a width
// sweep) share one stimulus bus; a bit-queue model predicts every output.
module tb_width_gearbox;

    localparam int NI = 5;

    function automatic int cfg_in(input int k);
        case (k)
            0: return 16;
            1: return 8;
            2: return 8;
            3: return 10;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_out(input int k);
        case (k)
            0: return 10;
            1: return 8;
            2: return 10;
            3: return 8;
            default: return 16;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic [15:0] d_in;
    logic        d_valid, d_flush, d_ready;

    logic [NI-1:0] v_in_ready, v_out_valid, v_out_last, v_done;
    logic [15:0]   v_out_data [NI];
    logic [7:0]    v_fill     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int IW = cfg_in(g);
        localparam int OW = cfg_out(g);
        localparam int CW = $clog2(IW + OW + 1);
        logic [OW-1:0] od;
        logic [CW-1:0] fl;
        logic          iv, fv;
        assign iv = d_valid && (sel == g);
        assign fv = d_flush && (sel == g);
        width_gearbox #(.IN_W(IW), .OUT_W(OW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_data    (d_in[IW-1:0]),
            .in_valid   (iv),
            .in_ready   (v_in_ready[g]),
            .flush      (fv),
            .out_data   (od),
            .out_valid  (v_out_valid[g]),
            .out_ready  (d_ready),
            .out_last   (v_out_last[g]),
            .flush_done (v_done[g]),
            .fill_level (fl)
        );
        assign v_out_data[g] = 16'(od);
        assign v_fill[g]     = 8'(fl);
    end

    int total, bad;

    // Reference model: a plain queue of stream bits, oldest first.
    bit   mq[$];
    bit   mflush, mdone;
    int   cur_in, cur_out;
    int   n_acc, n_pop, n_done;
    logic        e_in_ready, e_out_valid, e_last, e_done;
    logic [15:0] e_data;
    logic [7:0]  e_fill;

    function automatic void model_expect();
        int sz;
        sz          = mq.size();
        e_in_ready  = !mflush && (sz <= cur_out);
        e_out_valid = mflush ? (sz > 0) : (sz >= cur_out);
        e_last      = mflush && (sz > 0) && (sz < cur_out);
        e_done      = mdone;
        e_fill      = 8'(sz);
        e_data      = '0;
        for (int i = 0; i < cur_out; i++)
            if (i < sz) e_data[i] = mq[i];
    endfunction

    function automatic logic [11:0] obs_st();
        return {v_in_ready[sel], v_out_valid[sel], v_out_last[sel], v_done[sel], v_fill[sel]};
    endfunction

    function automatic logic [11:0] exp_st();
        return {e_in_ready, e_out_valid, e_last, e_done, e_fill};
    endfunction

    task automatic do_reset(input int k);
        sel = k; cur_in = cfg_in(k); cur_out = cfg_out(k);
        rst = 1'b1; d_valid = 1'b0; d_in = '0; d_flush = 1'b0; d_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); mflush = 1'b0; mdone = 1'b0;
        n_acc = 0; n_pop = 0; n_done = 0;
        model_expect();
    endtask

    // Drive one cycle of inputs, advance the model across the next edge.
    task automatic step(input logic iv, input logic [15:0] din, input logic fl, input logic rdy);
        bit was;
        int k;
        d_valid = iv; d_in = din; d_flush = fl; d_ready = rdy;
        was = mflush;
        if (e_out_valid && rdy) begin
            k = (mq.size() < cur_out) ? mq.size() : cur_out;
            repeat (k) mq.delete(0);
            n_pop++;
        end
        if (e_in_ready && iv) begin
            for (int i = 0; i < cur_in; i++) mq.push_back(din[i]);
            n_acc++;
        end
        mdone = 1'b0;
        if (was && mq.size() == 0) begin
            mflush = 1'b0; mdone = 1'b1; n_done++;
        end else if (!was && fl) begin
            mflush = 1'b1;
        end
        @(negedge clk);
        model_expect();
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            do_reset(k);
            total++;
            if ({v_in_ready[k], v_out_valid[k], v_out_last[k], v_done[k], v_fill[k], v_out_data[k]}
                !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0}) begin
                bad++;
                $display("FAIL reset[%0d]: got rdy=%b vld=%b last=%b done=%b fill=%0d data=%h want 1 0 0 0 0 0",
                         k, v_in_ready[k], v_out_valid[k], v_out_last[k], v_done[k], v_fill[k], v_out_data[k]);
            end
        end
    endtask

    task automatic test_basic_flush();
        logic        s_iv [7] = '{1, 1, 1, 0, 0, 0, 0};
        logic [15:0] s_d  [7] = '{16'hABCD, 16'hD234, 16'hD234, 0, 0, 0, 0};
        logic        s_fl [7] = '{0, 0, 0, 0, 1, 0, 0};
        logic [27:0] got, want;
        do_reset(0);
        for (int i = 0; i < 7; i++) begin
            step(s_iv[i], s_d[i], s_fl[i], 1'b1);
            total++;
            if (obs_st() !== exp_st()) begin
                bad++; $display("FAIL basic status step %0d: got %h want %h", i, obs_st(), exp_st());
            end
            // {in_ready, out_valid, out_last, flush_done, fill, out_data}
            got  = {v_in_ready[0], v_out_valid[0], v_out_last[0], v_done[0], v_fill[0], v_out_data[0]};
            want = 'x;
            case (i)
                0: want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd16, 16'h03CD};
                2: want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd22, 16'h012A};
                3: want = {1'b0, 1'b1, 1'b0, 1'b0, 8'd12, 16'h0123};
                4: want = {1'b0, 1'b1, 1'b1, 1'b0, 8'd2,  16'h0003};
                default: ;
            endcase
            if (i == 0 || (i >= 2 && i <= 4)) begin
                total++;
                if (got !== want) begin
                    bad++; $display("FAIL basic const step %0d: got %h want %h", i, got, want);
                end
            end
            if (i >= 5) begin
                total++;
                if ({v_in_ready[0], v_out_valid[0], v_done[0], v_fill[0]} !== {1'b1, 1'b0, (i == 5), 8'd0}) begin
                    bad++; $display("FAIL basic done step %0d: got rdy=%b vld=%b done=%b fill=%0d want 1 0 %b 0",
                                    i, v_in_ready[0], v_out_valid[0], v_done[0], v_fill[0], (i == 5));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] w [5];
        int  obs_pops;
        bit  rdy;
        bit  fin;
        do_reset(0);
        w[0] = 16'hABCD;
        for (int i = 1; i < 5; i++) w[i] = 16'($urandom);
        obs_pops = 0; fin = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (n_acc == 5 && mq.size() == 0) begin fin = 1; break; end
            rdy = (cyc >= 4);
            if (v_out_valid[0] && rdy) obs_pops++;
            step(n_acc < 5, w[(n_acc < 5) ? n_acc : 0], 1'b0, rdy);
            total++;
            if (obs_st() !== exp_st()) begin
                bad++; $display("FAIL bp status cyc %0d: got %h want %h", cyc, obs_st(), exp_st());
            end
            if (e_out_valid) begin
                total++;
                if (v_out_data[0] !== e_data) begin
                    bad++; $display("FAIL bp data cyc %0d: got %h want %h", cyc, v_out_data[0], e_data);
                end
            end
            if (cyc < 4) begin
                total++;
                if ({v_in_ready[0], v_fill[0], v_out_data[0]} !== {1'b0, 8'd16, 16'h03CD}) begin
                    bad++; $display("FAIL bp hold cyc %0d: got rdy=%b fill=%0d data=%h want 0 16 03cd",
                                    cyc, v_in_ready[0], v_fill[0], v_out_data[0]);
                end
            end
        end
        total++;
        if (!fin || obs_pops != 8 || v_fill[0] !== 8'd0) begin
            bad++; $display("FAIL bp drain: got pops=%0d fill=%0d done=%0d want pops=8 fill=0 done=1",
                            obs_pops, v_fill[0], fin);
        end
    endtask

    task automatic test_flush_edge();
        int  pulses, lasts;
        bit  fin;
        logic s_fl [3] = '{1, 1, 0};
        do_reset(0);
        pulses = 0; lasts = 0; fin = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, s_fl[i], 1'b1);
            if (v_done[0]) pulses++;
            total++;
            if (obs_st() !== exp_st()) begin
                bad++; $display("FAIL flush0 status step %0d: got %h want %h", i, obs_st(), exp_st());
            end
            total++;
            if ({v_in_ready[0], v_out_valid[0], v_done[0]} !== {(i != 0), 1'b0, (i == 1)}) begin
                bad++; $display("FAIL flush0 const step %0d: got rdy=%b vld=%b done=%b want %b 0 %b",
                                i, v_in_ready[0], v_out_valid[0], v_done[0], (i != 0), (i == 1));
            end
        end
        step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (v_out_valid[0] && v_out_last[0]) lasts++;
            step(1'b0, '0, 1'b1, 1'b1);
            total++;
            if (obs_st() !== exp_st()) begin
                bad++; $display("FAIL flushd status cyc %0d: got %h want %h", cyc, obs_st(), exp_st());
            end
            if (e_out_valid) begin
                total++;
                if (v_out_data[0] !== e_data) begin
                    bad++; $display("FAIL flushd data cyc %0d: got %h want %h", cyc, v_out_data[0], e_data);
                end
            end
            if (v_done[0]) begin pulses++; fin = 1; break; end
        end
        total++;
        if (!fin || pulses != 2 || lasts != 1) begin
            bad++; $display("FAIL flush pulses: got done=%0d lasts=%0d fin=%0d want 2 1 1", pulses, lasts, fin);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(0);
        step(1'b1, 16'hABCD, 1'b0, 1'b1);
        step(1'b1, 16'hD234, 1'b0, 1'b1);
        step(1'b1, 16'hD234, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        total++;
        if ({v_out_valid[0], v_fill[0]} !== {1'b1, 8'd12}) begin
            bad++; $display("FAIL mrst pre: got vld=%b fill=%0d want 1 12", v_out_valid[0], v_fill[0]);
        end
        rst = 1'b1; d_valid = 1'b1; d_in = 16'h5555; d_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({v_out_valid[0], v_fill[0], v_in_ready[0], v_out_last[0]} !== {1'b0, 8'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL mrst state: got vld=%b fill=%0d rdy=%b last=%b want 0 0 1 0",
                            v_out_valid[0], v_fill[0], v_in_ready[0], v_out_last[0]);
        end
        rst = 1'b0;
        mq.delete(); mflush = 1'b0; mdone = 1'b0;
        model_expect();
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        total++;
        if ({v_out_valid[0], v_fill[0], v_out_data[0]} !== {1'b1, 8'd16, 16'h0234}) begin
            bad++; $display("FAIL mrst align: got vld=%b fill=%0d data=%h want 1 16 0234",
                            v_out_valid[0], v_fill[0], v_out_data[0]);
        end
        total++;
        if (obs_st() !== exp_st()) begin
            bad++; $display("FAIL mrst status: got %h want %h", obs_st(), exp_st());
        end
    endtask

    task automatic test_sweep();
        logic [15:0] w [20];
        int  nw, obs_pops, lasts, want_pops, want_lasts;
        bit  iv, rdy, fl, sent, fin;
        for (int k = 0; k < NI; k++) begin
            do_reset(k);
            nw = 12 + int'($urandom_range(0, 7));
            for (int i = 0; i < 20; i++) w[i] = 16'($urandom);
            obs_pops = 0; lasts = 0; sent = 0; fin = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                iv  = (n_acc < nw) && ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 2) != 0);
                fl  = (n_acc == nw) && !sent;
                if (fl) sent = 1;
                if (v_out_valid[k] && rdy) begin
                    obs_pops++;
                    if (v_out_last[k]) lasts++;
                end
                step(iv, w[(n_acc < nw) ? n_acc : 0], fl, rdy);
                total++;
                if (obs_st() !== exp_st()) begin
                    bad++; $display("FAIL sweep%0d status cyc %0d: got %h want %h", k, cyc, obs_st(), exp_st());
                end
                if (e_out_valid) begin
                    total++;
                    if (v_out_data[k] !== e_data) begin
                        bad++; $display("FAIL sweep%0d data cyc %0d: got %h want %h", k, cyc, v_out_data[k], e_data);
                    end
                end
                if (v_done[k]) begin fin = 1; break; end
            end
            want_pops  = (nw * cur_in + cur_out - 1) / cur_out;
            want_lasts = ((nw * cur_in) % cur_out != 0) ? 1 : 0;
            total++;
            if (!fin || obs_pops != want_pops || lasts != want_lasts || v_fill[k] !== 8'd0) begin
                bad++; $display("FAIL sweep%0d end: got fin=%0d pops=%0d lasts=%0d fill=%0d want 1 %0d %0d 0",
                                k, fin, obs_pops, lasts, v_fill[k], want_pops, want_lasts);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; sel = 0; d_in = '0; d_valid = 1'b0; d_flush = 1'b0; d_ready = 1'b0;
        test_reset();
        test_basic_flush();
        test_backpressure();
        test_flush_edge();
        test_mid_reset();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
